// File: rtl/mem_line_responder.sv
// Main-memory responder for cache line fills and write-backs.
// One request in flight; fixed latency; one-cycle ready pulse on completion.
module mem_line_responder #(
    parameter int unsigned LATENCY = 5,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned LINE_W  = 128
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [LINE_W-1:0] mem_wdata_i,
    output logic              mem_busy_o,
    output logic              mem_data_ready_o,
    output logic [LINE_W-1:0] mem_data_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] data_q, data_d;

    logic [LINE_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              acc_en;
    logic              acc_we;
    logic [IDX_W-1:0]  acc_idx;
    logic [LINE_W-1:0] acc_wdata;
    logic [IDX_W-1:0]  in_idx;
    logic              unused_addr;

    assign in_idx      = mem_addr_i[4 +: IDX_W];
    assign unused_addr = ^{mem_addr_i[3:0], mem_addr_i[ADDR_W-1:4+IDX_W]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        accept    = 1'b0;
        acc_en    = 1'b0;
        acc_we    = we_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        // Single-cycle latency: access straight from the request inputs.
                        state_d   = ST_RESP;
                        acc_en    = 1'b1;
                        acc_we    = mem_we_i;
                        acc_idx   = in_idx;
                        acc_wdata = mem_wdata_i;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = ST_RESP;
                    acc_en  = 1'b1;
                end
            end
            ST_RESP: begin
                if (mem_req_i) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            idx_d   = in_idx;
            we_d    = mem_we_i;
            wdata_d = mem_wdata_i;
            cnt_d   = CNT_INIT;
        end

        if (acc_en) begin
            data_d = acc_we ? acc_wdata : mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // Storage is not reset; a write only commits on the edge that enters RESP.
    always_ff @(posedge clk_i) begin
        if (acc_en && acc_we && !rsn_i) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign mem_busy_o       = (state_q == ST_WAIT);
    assign mem_data_ready_o = (state_q == ST_RESP);
    assign mem_data_o       = data_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: LATENCY=5 instance plus a LATENCY=1 instance.
module tb_mem_line_responder;

    logic         clk;
    logic         rst;
    logic         req, we;
    logic [19:0]  addr;
    logic [127:0] wdata;
    logic         busy, ready;
    logic [127:0] data;

    logic         req1, we1;
    logic [19:0]  addr1;
    logic [127:0] wdata1;
    logic         busy1, ready1;
    logic [127:0] data1;

    int checks;
    int failures;

    localparam logic [127:0] LINE_A   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] LINE_55  = {16{8'h55}};
    localparam logic [127:0] LINE_A5  = {16{8'hA5}};
    localparam logic [127:0] LINE_11  = {16{8'h11}};
    localparam logic [127:0] LINE_OLD = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [127:0] LINE_X   = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

    mem_line_responder #(.LATENCY(5)) u_dut (
        .clk_i           (clk),
        .rsn_i           (rst),
        .mem_req_i       (req),
        .mem_we_i        (we),
        .mem_addr_i      (addr),
        .mem_wdata_i     (wdata),
        .mem_busy_o      (busy),
        .mem_data_ready_o(ready),
        .mem_data_o      (data)
    );

    mem_line_responder #(.LATENCY(1)) u_dut1 (
        .clk_i           (clk),
        .rsn_i           (rst),
        .mem_req_i       (req1),
        .mem_we_i        (we1),
        .mem_addr_i      (addr1),
        .mem_wdata_i     (wdata1),
        .mem_busy_o      (busy1),
        .mem_data_ready_o(ready1),
        .mem_data_o      (data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues a request, checks 4 busy cycles, returns while in the RESP cycle.
    task automatic txn(input logic w, input logic [19:0] a, input logic [127:0] d,
                       input logic [127:0] exp, input string tag);
        req = 1'b1; we = w; addr = a; wdata = d;
        tick();
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_wait%0d", tag, i), {126'd0, busy, ready}, 128'b10);
            tick();
        end
        chk({tag, "_ready"}, {126'd0, busy, ready}, 128'b01);
        chk({tag, "_data"}, data, exp);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        tick();
        tick();
        chk("reset_outputs", {busy, ready, data}, '0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle%0d", i), {busy, ready, data}, '0);
        end

        // Write then read, different byte offsets within one line.
        txn(1'b1, 20'h00120, LINE_A, LINE_A, "wr120");
        tick();
        chk("after_wr_ready_low", {127'd0, ready}, '0);
        chk("after_wr_data_hold", data, LINE_A);
        txn(1'b0, 20'h0012C, '0, LINE_A, "rd12C");
        tick();

        // Back-to-back: read issued in the write's RESP cycle.
        txn(1'b1, 20'h00010, LINE_55, LINE_55, "wr010");
        txn(1'b0, 20'h00010, '0, LINE_55, "rd010_b2b");
        tick();

        // Pre-write 0x200, then show a request during WAIT is ignored.
        txn(1'b1, 20'h00200, LINE_11, LINE_11, "wr200");
        tick();
        req = 1'b1; we = 1'b0; addr = 20'h00120;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1; we = 1'b1; addr = 20'h00200; wdata = '1;
        tick();
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tick();
        tick();
        chk("ign_ready", {126'd0, busy, ready}, 128'b01);
        chk("ign_data", data, LINE_A);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("ign_no_pulse%0d", i), {126'd0, busy, ready}, '0);
        end
        txn(1'b0, 20'h00200, '0, LINE_11, "rd200_unchanged");
        tick();

        // Aliasing across the 64 KiB boundary.
        txn(1'b1, 20'h10040, LINE_A5, LINE_A5, "wr10040");
        tick();
        txn(1'b0, 20'h00040, '0, LINE_A5, "rd00040");
        tick();

        // Reset mid-write drops the pending write.
        txn(1'b1, 20'h00300, LINE_OLD, LINE_OLD, "wr300_old");
        tick();
        req = 1'b1; we = 1'b1; addr = 20'h00300; wdata = '1;
        tick();
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {busy, ready, data}, '0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("midrst_no_pulse%0d", i), {busy, ready, data}, '0);
        end
        txn(1'b0, 20'h00300, '0, LINE_OLD, "rd300_after_rst");
        tick();

        // LATENCY=1: ready the next cycle, then every other cycle under continuous requests.
        req1 = 1'b1; we1 = 1'b1; addr1 = 20'h00050; wdata1 = LINE_X;
        tick();
        chk("l1_wr_ready", {126'd0, busy1, ready1}, 128'b01);
        chk("l1_wr_data", data1, LINE_X);
        we1 = 1'b0; wdata1 = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("l1_gap%0d", i), {126'd0, busy1, ready1}, 128'b10);
            tick();
            chk($sformatf("l1_ready%0d", i), {126'd0, busy1, ready1}, 128'b01);
            chk($sformatf("l1_data%0d", i), data1, LINE_X);
        end
        req1 = 1'b0;
        tick();
        tick();
        chk("l1_idle", {126'd0, busy1, ready1}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
